// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if -- request/result bus for shift_sequencer.
//   Request : in_valid / in_ready handshake carrying A, FuncCode, Amount.
//   Result  : out_valid / out_ready handshake carrying C, CarryOut,
//             OverflowFlag.
//   master  : the requester/consumer side (drives requests, takes results).
//   slave   : the sequencer side.
interface shift_sequencer_if #(
   parameter int data_width = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [data_width-1:0] A;
   logic [3:0]            FuncCode;
   logic [3:0]            Amount;
   logic                  out_valid;
   logic                  out_ready;
   logic [data_width-1:0] C;
   logic                  CarryOut;
   logic                  OverflowFlag;

   modport master (
      output in_valid, A, FuncCode, Amount, out_ready,
      input  in_ready, out_valid, C, CarryOut, OverflowFlag
   );

   modport slave (
      input  in_valid, A, FuncCode, Amount, out_ready,
      output in_ready, out_valid, C, CarryOut, OverflowFlag
   );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer -- multi-cycle shifter (LSL/LSR/ASL/ASR) with a
// valid/ready request side and a valid/ready result side.
//   clk   : single clock, all state on rising edge
//   reset : synchronous, active-high; discards any in-flight request
//   bus   : shift_sequencer_if.slave
//             in_valid/in_ready, A, FuncCode, Amount  (request)
//             out_valid/out_ready, C, CarryOut, OverflowFlag (result)
// FuncCode: 1010 LSL, 1011 LSR, 1100 ASL, 1101 ASR; anything else yields
// C=0, CarryOut=0 after one edge.
// Optional build macro SHIFT_SEQ_FAST_EN: shift two bits per SHIFT cycle
// while at least two remain (same results, shorter latency).
module shift_sequencer #(
   parameter int data_width = 16
) (
   input  logic             clk,
   input  logic             reset,
   shift_sequencer_if.slave bus
);

   localparam logic [3:0] FC_LSL = 4'b1010;
   localparam logic [3:0] FC_LSR = 4'b1011;
   localparam logic [3:0] FC_ASL = 4'b1100;
   localparam logic [3:0] FC_ASR = 4'b1101;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                state_q, state_d;
   logic [data_width-1:0] work_q, work_d;
   logic                  carry_q, carry_d;
   logic [3:0]            rem_q, rem_d;
   logic [3:0]            func_q, func_d;

   logic                  code_ok;
   logic                  left;
   logic                  fill;
   logic [3:0]            step;

   assign code_ok = (bus.FuncCode == FC_LSL) || (bus.FuncCode == FC_LSR) ||
                    (bus.FuncCode == FC_ASL) || (bus.FuncCode == FC_ASR);
   assign left    = (func_q == FC_LSL) || (func_q == FC_ASL);
   // Only ASR replicates the sign bit; the logical right shift fills 0.
   assign fill    = (func_q == FC_ASR) & work_q[data_width-1];

`ifdef SHIFT_SEQ_FAST_EN
   assign step = (rem_q >= 4'd2) ? 4'd2 : 4'd1;
`else
   assign step = 4'd1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         work_q  <= '0;
         carry_q <= 1'b0;
         rem_q   <= '0;
         func_q  <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         carry_q <= carry_d;
         rem_q   <= rem_d;
         func_q  <= func_d;
      end
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      carry_d = carry_q;
      rem_d   = rem_q;
      func_d  = func_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               func_d  = bus.FuncCode;
               carry_d = 1'b0;
               if (!code_ok) begin
                  work_d  = '0;
                  rem_d   = '0;
                  state_d = DONE;
               end else if (bus.Amount == 4'd0) begin
                  work_d  = bus.A;
                  rem_d   = '0;
                  state_d = DONE;
               end else begin
                  work_d  = bus.A;
                  rem_d   = bus.Amount;
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (step == 4'd2) begin
               if (left) begin
                  work_d  = {work_q[data_width-3:0], 2'b00};
                  carry_d = work_q[data_width-2];
               end else begin
                  work_d  = {{2{fill}}, work_q[data_width-1:2]};
                  carry_d = work_q[1];
               end
            end else begin
               if (left) begin
                  work_d  = {work_q[data_width-2:0], 1'b0};
                  carry_d = work_q[data_width-1];
               end else begin
                  work_d  = {fill, work_q[data_width-1:1]};
                  carry_d = work_q[0];
               end
            end
            // Final step consumes whatever distance is left.
            if (rem_q <= step) begin
               rem_d   = '0;
               state_d = DONE;
            end else begin
               rem_d = rem_q - step;
            end
         end
         DONE: begin
            // Returning edge never accepts: state is DONE, not IDLE.
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready     = (state_q == IDLE);
   assign bus.out_valid    = (state_q == DONE);
   assign bus.C            = work_q;
   assign bus.CarryOut     = carry_q;
   assign bus.OverflowFlag = 1'b0;

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter data_width, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, request present.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept a request.
REQ-006 The block SHALL have port A, input, data_width, operand to shift.
REQ-007 The block SHALL have port FuncCode, input, 4, operation: 1010 LSL, 1011 LSR, 1100 ASL, 1101 ASR.
REQ-008 The block SHALL have port Amount, input, 4, shift distance 0..15.
REQ-009 The block SHALL have port out_valid, output, 1, result present.
REQ-010 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 The block SHALL have port C, output, data_width, shifted result.
REQ-012 The block SHALL have port CarryOut, output, 1, last bit shifted out; 0 if no bit was shifted out.
REQ-013 The block SHALL have port OverflowFlag, output, 1, always 0.

Function
REQ-014 The block SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 On an edge with in_valid=1 in IDLE, the block SHALL capture A, FuncCode and Amount.
- Go to DONE if Amount=0 or FuncCode is not one of the four codes.
- Otherwise go to SHIFT with remaining=Amount.
REQ-017 Each SHIFT cycle SHALL shift the working value by one bit and decrement remaining.
- LSL and ASL: shift left, fill 0, CarryOut=old MSB.
- LSR: shift right, fill 0, CarryOut=old LSB.
- ASR: shift right, fill old MSB, CarryOut=old LSB.
REQ-018 When remaining=1 at an edge in SHIFT, the block SHALL perform the final shift and go to DONE.
- Result: out_valid rises exactly Amount+1 edges after the accepting edge; exactly 1 edge when Amount=0.
REQ-019 For an invalid FuncCode, C SHALL be 0 and CarryOut 0 in DONE.
REQ-020 For Amount=0 with a valid FuncCode, C SHALL equal the captured A and CarryOut 0.
REQ-021 In DONE, C and CarryOut SHALL hold stable until an edge with out_ready=1; that edge returns to IDLE.
- No new request is accepted on that same edge (minimum 1 idle cycle between results).
REQ-022 Inputs A, FuncCode and Amount SHALL be ignored outside the accepting edge; changes mid-operation do not affect the result.
REQ-023 A, FuncCode and Amount SHALL be ignored when in_valid=0 or the state is not IDLE.
REQ-024 ASR by Amount 15 SHALL yield all bits equal to the original MSB; LSL/LSR by 15 leave exactly one original bit.

Reset
REQ-025 While reset=1 at an edge, the block SHALL enter IDLE with remaining=0, C=0, CarryOut=0, out_valid=0, in_ready=1 and OverflowFlag=0.
REQ-026 Reset SHALL take priority over all other events, including in SHIFT or DONE.
- Any in-flight request is discarded with no result produced.

Configuration
REQ-027 With macro SHIFT_SEQ_FAST_EN defined, each SHIFT cycle SHALL shift by 2 when remaining>=2, else by 1.
- Latency becomes ceil(Amount/2)+1 edges.
- CarryOut is the last bit shifted out.
- Results are identical to the undefined case.
REQ-028 Without SHIFT_SEQ_FAST_EN, the block SHALL shift exactly 1 bit per SHIFT cycle as in REQ-017.

Verification
REQ-029 Reset mid-SHIFT: A=16'h8001, FuncCode=1010, Amount=3, reset asserted at the 2nd SHIFT edge -> IDLE, out_valid=0, no result ever produced.
REQ-030 Basic LSL, default build: A=16'h8001, FuncCode=1010, Amount=3 -> out_valid 4 edges after accept, C=16'h0008, CarryOut=0.
REQ-031 ASR: A=16'h8000, FuncCode=1101, Amount=15 -> C=16'hFFFF, CarryOut=0; LSR, same A and Amount -> C=16'h0001.
REQ-032 Edge cases: Amount=0 with FuncCode=1011, A=16'h1234 -> C=16'h1234 after 1 edge; FuncCode=0000 -> C=16'h0000.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE -> C stable, in_ready=0; new in_valid ignored until after the out_ready=1 edge.
REQ-034 Fast build: SHIFT_SEQ_FAST_EN defined, A=16'h0003, FuncCode=1011, Amount=5 -> out_valid 4 edges after accept, C=16'h0000, CarryOut=0.
